decoder_n_scan: RTL and testbench

Parametrised N-to-2^N decoder with registered, active-low one-hot outputs and an active-low enable. It adds two features:
- break-before-make blanking between output changes;
- an autonomous SCAN mode that walks every output in turn with a programmable dwell, using a start/busy/done handshake.

It drives active-low selects (chip selects, LED/row strobes) wherever a fixed 2:4 decoder is no longer enough.

---
 rtl/decoder_n_scan_if.sv | 28 ++
 rtl/decoder_n_scan.sv | 173 +++++++++++++++++
 tb/tb_decoder_n_scan.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_n_scan_if.sv
// Bus bundle for decoder_n_scan: control inputs toward the decoder and the
// registered select / scan-status outputs back to the controller.
interface decoder_n_scan_if #(
   parameter int N = 2
);
   localparam int NOUT = 1 << N;

   logic            en_n;
   logic            mode;
   logic [N-1:0]    sel;
   logic            start;
   logic [NOUT-1:0] y;
   logic [N-1:0]    idx;
   logic            busy;
   logic            done;

   // Controller side: drives enable/mode/select/start, observes outputs.
   modport master (
      output en_n, mode, sel, start,
      input  y, idx, busy, done
   );

   // Decoder side.
   modport slave (
      input  en_n, mode, sel, start,
      output y, idx, busy, done
   );
endinterface

// File: rtl/decoder_n_scan.sv
// N-to-2^N decoder with registered active-low one-hot outputs, optional
// break-before-make blanking between different outputs, and an autonomous
// SCAN mode that walks every output with a programmable dwell time.
module decoder_n_scan #(
   parameter int N     = 2,
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   decoder_n_scan_if.slave  bus
);
   localparam int NOUT = 1 << N;
   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
   localparam logic [N-1:0]    IDX_LAST   = N'(NOUT - 1);
   localparam logic [NOUT-1:0] ALL_HIGH   = {NOUT{1'b1}};
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
   localparam logic [N-1:0]    IDX_ONE    = N'(1);
   localparam logic            HAS_GAP    = (BLANK > 0);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRIVE    = 3'd1,
      ST_GAP      = 3'd2,
      ST_SCAN_ON  = 3'd3,
      ST_SCAN_GAP = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [NOUT-1:0] y_q, y_d;
   logic [N-1:0]    idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Active-low one-hot pattern for a given output index.
   function automatic logic [NOUT-1:0] low_sel(input logic [N-1:0] s);
      logic [NOUT-1:0] one;
      one     = {{(NOUT-1){1'b0}}, 1'b1};
      low_sel = ~(one << s);
   endfunction

   // Next-state and next-output computation; en_n overrides everything.
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      if (bus.en_n) begin
         state_d = ST_IDLE;
         y_d     = ALL_HIGH;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!bus.mode) begin
                  state_d = ST_DRIVE;
                  y_d     = low_sel(bus.sel);
                  idx_d   = bus.sel;
               end else if (bus.start) begin
                  state_d = ST_SCAN_ON;
                  y_d     = low_sel('0);
                  idx_d   = '0;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  y_d = ALL_HIGH;
               end
            end
            ST_DRIVE: begin
               if (bus.mode) begin
                  state_d = ST_IDLE;
                  y_d     = ALL_HIGH;
               end else if (bus.sel != idx_q) begin
                  if (HAS_GAP) begin
                     state_d = ST_GAP;
                     y_d     = ALL_HIGH;
                     cnt_d   = '0;
                  end else begin
                     y_d   = low_sel(bus.sel);
                     idx_d = bus.sel;
                  end
               end else begin
                  y_d = y_q;
               end
            end
            ST_GAP: begin
               if (bus.mode) begin
                  state_d = ST_IDLE;
                  y_d     = ALL_HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == BLANK_LAST) begin
                  // Drive whatever sel holds when the blanking ends.
                  state_d = ST_DRIVE;
                  y_d     = low_sel(bus.sel);
                  idx_d   = bus.sel;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_SCAN_ON: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     // Last output done: no trailing gap, finish the scan.
                     state_d = ST_IDLE;
                     y_d     = ALL_HIGH;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else if (HAS_GAP) begin
                     state_d = ST_SCAN_GAP;
                     y_d     = ALL_HIGH;
                  end else begin
                     idx_d = idx_q + IDX_ONE;
                     y_d   = low_sel(idx_q + IDX_ONE);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_SCAN_GAP: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SCAN_ON;
                  idx_d   = idx_q + IDX_ONE;
                  y_d     = low_sel(idx_q + IDX_ONE);
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               y_d     = ALL_HIGH;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         y_q     <= ALL_HIGH;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.y    = y_q;
   assign bus.idx  = idx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: two instances (N=2/DWELL=4/BLANK=1 and
// N=3/DWELL=2/BLANK=0) driven with directed and random stimulus and compared
// every cycle against a behavioural model.
module tb_decoder_n_scan;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   decoder_n_scan_if #(.N(2)) if_a ();
   decoder_n_scan_if #(.N(3)) if_b ();

   decoder_n_scan #(.N(2), .DWELL(4), .BLANK(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a.slave)
   );

   decoder_n_scan #(.N(3), .DWELL(2), .BLANK(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b.slave)
   );

   // Model state: y_idx = active output (-1 none), scan_t = cycles since
   // scan launch (-1 not scanning), gap_left = remaining decode gap cycles.
   typedef struct {
      int y_idx;
      int idx;
      bit busy;
      bit done;
      int scan_t;
      int gap_left;
      bit drv;
   } mdl_t;

   mdl_t ma, mb;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt_a = 0;
   int   done_cnt_a = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mdl_t mdl_reset();
      mdl_t s;
      s.y_idx = -1; s.idx = 0; s.busy = 1'b0; s.done = 1'b0;
      s.scan_t = -1; s.gap_left = -1; s.drv = 1'b0;
      return s;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s_in, input int nout, input int dwell,
                                     input int blank, input bit en_n, input bit mode,
                                     input bit start, input int sel);
      mdl_t s;
      int   len, slot, off;
      s      = s_in;
      s.done = 1'b0;
      len    = nout * dwell + (nout - 1) * blank;
      if (en_n) begin
         s.y_idx = -1; s.busy = 1'b0; s.scan_t = -1; s.gap_left = -1; s.drv = 1'b0;
      end else if (s.scan_t >= 0) begin
         s.scan_t++;
         if (s.scan_t == len) begin
            s.y_idx = -1; s.busy = 1'b0; s.done = 1'b1; s.scan_t = -1;
         end else begin
            slot = s.scan_t / (dwell + blank);
            off  = s.scan_t % (dwell + blank);
            if (off < dwell) begin
               s.y_idx = slot; s.idx = slot;
            end else begin
               s.y_idx = -1;
            end
         end
      end else if (mode) begin
         if (s.drv || s.gap_left >= 0) begin
            s.y_idx = -1; s.drv = 1'b0; s.gap_left = -1;
         end else if (start) begin
            s.scan_t = 0; s.busy = 1'b1; s.idx = 0; s.y_idx = 0;
         end
      end else if (s.gap_left > 0) begin
         s.gap_left--;
      end else if (s.gap_left == 0 || !s.drv || (blank == 0 && sel != s.idx)) begin
         s.y_idx = sel; s.idx = sel; s.drv = 1'b1; s.gap_left = -1;
      end else if (sel != s.idx) begin
         s.drv = 1'b0; s.gap_left = blank - 1; s.y_idx = -1;
      end
      return s;
   endfunction

   function automatic logic [31:0] exp_y(input int nout, input int yi);
      logic [31:0] m;
      m = (32'd1 << nout) - 32'd1;
      if (yi < 0) return m;
      return m & ~(32'd1 << yi);
   endfunction

   task automatic set_in(input bit en, input bit md, input bit st, input int s);
      if_a.en_n  = en;  if_b.en_n  = en;
      if_a.mode  = md;  if_b.mode  = md;
      if_a.start = st;  if_b.start = st;
      if_a.sel   = s[1:0];
      if_b.sel   = s[2:0];
   endtask

   task automatic check_all();
      check_eq("a_y",    32'(if_a.y),    exp_y(4, ma.y_idx));
      check_eq("a_idx",  32'(if_a.idx),  32'(ma.idx));
      check_eq("a_busy", 32'(if_a.busy), 32'(ma.busy));
      check_eq("a_done", 32'(if_a.done), 32'(ma.done));
      check_eq("b_y",    32'(if_b.y),    exp_y(8, mb.y_idx));
      check_eq("b_idx",  32'(if_b.idx),  32'(mb.idx));
      check_eq("b_busy", 32'(if_b.busy), 32'(mb.busy));
      check_eq("b_done", 32'(if_b.done), 32'(mb.done));
   endtask

   // One clock: step the model with the inputs present at the edge, then compare.
   task automatic cycle();
      @(posedge clk);
      if (!rst_n) begin
         ma = mdl_reset();
         mb = mdl_reset();
      end else begin
         ma = mdl_step(ma, 4, 4, 1, if_a.en_n, if_a.mode, if_a.start, int'(if_a.sel));
         mb = mdl_step(mb, 8, 2, 0, if_b.en_n, if_b.mode, if_b.start, int'(if_b.sel));
      end
      #1;
      check_all();
      busy_cnt_a += int'(if_a.busy);
      done_cnt_a += int'(if_a.done);
   endtask

   initial begin
      bit en_r, md_r;
      int sel_r;
      rst_n = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, 0);
      ma = mdl_reset();
      mb = mdl_reset();
      #1 rst_n = 1'b0;
      #2;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Decode from idle, then a change with one blanking cycle.
      set_in(1'b0, 1'b0, 1'b0, 0);
      cycle();
      check_eq("t2_first", 32'(if_a.y), 32'h0000000e);
      set_in(1'b0, 1'b0, 1'b0, 2);
      cycle();
      check_eq("t2_gap", 32'(if_a.y), 32'h0000000f);
      cycle();
      check_eq("t2_sel2", 32'(if_a.y), 32'h0000000b);
      check_eq("t2_idx", 32'(if_a.idx), 32'd2);

      // Enable off then on with a new select.
      set_in(1'b1, 1'b0, 1'b0, 2);
      cycle();
      check_eq("t3_off", 32'(if_a.y), 32'h0000000f);
      set_in(1'b0, 1'b0, 1'b0, 3);
      cycle();
      check_eq("t3_on", 32'(if_a.y), 32'h00000007);

      // Full scan; mode/sel/start toggled randomly while busy must not matter.
      set_in(1'b0, 1'b1, 1'b0, 0);
      cycle();
      check_eq("t4_leave_drive", 32'(if_a.y), 32'h0000000f);
      busy_cnt_a = 0;
      done_cnt_a = 0;
      set_in(1'b0, 1'b1, 1'b1, 0);
      cycle();
      for (int i = 0; i < 19; i++) begin
         set_in(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(7)));
         cycle();
      end
      set_in(1'b0, 1'b1, 1'b0, 0);
      repeat (5) cycle();
      check_eq("t4_busy_cycles", 32'(busy_cnt_a), 32'd19);
      check_eq("t4_done_pulses", 32'(done_cnt_a), 32'd1);

      // Abort: restart attempt while busy, then disable during output 1.
      done_cnt_a = 0;
      set_in(1'b0, 1'b1, 1'b1, 0);
      cycle();
      set_in(1'b0, 1'b1, 1'b0, 0);
      cycle();
      set_in(1'b0, 1'b1, 1'b1, 0);
      cycle();
      set_in(1'b0, 1'b1, 1'b0, 0);
      repeat (3) cycle();
      check_eq("t5_out1", 32'(if_a.y), 32'h0000000d);
      set_in(1'b1, 1'b1, 1'b0, 0);
      cycle();
      check_eq("t5_abort_y", 32'(if_a.y), 32'h0000000f);
      check_eq("t5_abort_busy", 32'(if_a.busy), 32'd0);
      set_in(1'b0, 1'b1, 1'b0, 0);
      repeat (4) cycle();
      check_eq("t5_no_done", 32'(done_cnt_a), 32'd0);

      // Wide decoder without blanking switches on the very next edge.
      set_in(1'b0, 1'b0, 1'b0, 5);
      cycle();
      check_eq("t6_sel5", 32'(if_b.y), 32'h000000df);
      set_in(1'b0, 1'b0, 1'b0, 6);
      cycle();
      check_eq("t6_sel6", 32'(if_b.y), 32'h000000bf);
      check_eq("t6_idx", 32'(if_b.idx), 32'd6);

      // Asynchronous reset in the middle of a scan.
      set_in(1'b0, 1'b1, 1'b0, 0);
      cycle();
      set_in(1'b0, 1'b1, 1'b1, 0);
      cycle();
      set_in(1'b0, 1'b1, 1'b0, 0);
      repeat (6) cycle();
      #2 rst_n = 1'b0;
      #1;
      check_eq("t1_rst_y", 32'(if_a.y), 32'h0000000f);
      check_eq("t1_rst_busy", 32'(if_a.busy), 32'd0);
      check_eq("t1_rst_done", 32'(if_a.done), 32'd0);
      ma = mdl_reset();
      mb = mdl_reset();
      check_all();
      @(negedge clk) rst_n = 1'b1;
      repeat (3) cycle();
      check_eq("t1_idle_after", 32'(if_a.y), 32'h0000000f);

      // Random stimulus against the model.
      en_r  = 1'b0;
      md_r  = 1'b0;
      sel_r = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(15) == 0) en_r = ~en_r;
         if ($urandom_range(9) == 0) md_r = ~md_r;
         if ($urandom_range(2) == 0) sel_r = int'($urandom_range(7));
         set_in(en_r, md_r, ($urandom_range(5) == 0), sel_r);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
